// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared LSU state encoding, load mask constants and pass-through bundle type
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [31:0] RMASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] RMASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] RMASK_WORD = 32'hFFFF_FFFF;

    // Fields carried untouched from exu to wbu.
    typedef struct packed {
        logic [1:0]  wd_op;
        logic        csrwd_op;
        logic        reg_write_en;
        logic        csreg_write_en;
        logic        ecall;
        logic [4:0]  rd;
        logic [1:0]  csr_rd;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] instruction;
    } lsu_pass_t;

endpackage

// File: rtl/lsu_load_ext.sv
// rtl/lsu_load_ext.sv - load data alignment, masking and sign extension
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [31:0] rmask,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [31:0] raw;
    logic [31:0] masked;

    always_comb begin
        raw    = rdata >> {off, 3'b000};
        masked = raw & rmask;
        data   = masked;
        if (is_signed && rmask == RMASK_BYTE) begin
            data = {{24{masked[7]}}, masked[7:0]};
        end else if (is_signed && rmask == RMASK_HALF) begin
            data = {{16{masked[15]}}, masked[15:0]};
        end
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit between exu and wbu; optional LSU_MISALIGN_CHECK_EN
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_receive_valid,
    output logic        lsu_send_ready,
    input  logic [31:0] alu_result_input,
    input  logic [31:0] rsb_input,
    input  logic        ren_input,
    input  logic        wen_input,
    input  logic [7:0]  wmask_input,
    input  logic [31:0] rmask_input,
    input  logic        memory_read_signed_input,
    input  logic [1:0]  wdOp_input,
    input  logic        csrwdOp_input,
    input  logic        reg_write_en_input,
    input  logic        csreg_write_en_input,
    input  logic        ecall_input,
    input  logic [4:0]  rd_input,
    input  logic [1:0]  csr_rd_input,
    input  logic [31:0] pc_input,
    input  logic [31:0] pc_next_input,
    input  logic [31:0] instruction_input,
    output logic        lsu_send_valid,
    input  logic        lsu_receive_ready,
    output logic [31:0] alu_result,
    output logic [31:0] mem_rdata,
    output logic [1:0]  wdOp,
    output logic        csrwdOp,
    output logic        reg_write_en,
    output logic        csreg_write_en,
    output logic        ecall,
    output logic [4:0]  rd,
    output logic [1:0]  csr_rd,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic [31:0] instruction,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic        lsu_misalign,
`endif
    input  logic [31:0] mem_resp_rdata
);

    lsu_state_e  state_q, state_d;
    lsu_pass_t   pass_q, pass_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] rsb_q, rsb_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [31:0] rmask_q, rmask_d;
    logic        signed_q, signed_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [31:0] load_data;
    logic        misalign_hit;

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic half_acc, word_acc;

    // A bundle with both ren and wen is a store, so its size comes from wmask.
    assign half_acc = wen_input ? (wmask_input == 8'h03) : (rmask_input == RMASK_HALF);
    assign word_acc = wen_input ? (wmask_input == 8'h0F) : (rmask_input == RMASK_WORD);
    assign misalign_hit = (ren_input | wen_input) &&
                          ((half_acc && alu_result_input[0]) ||
                           (word_acc && alu_result_input[1:0] != 2'b00));

    always_comb begin
        misalign_d = misalign_q;
        if (state_q == IDLE && lsu_receive_valid) begin
            misalign_d = misalign_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign lsu_misalign = misalign_q;
`else
    assign misalign_hit = 1'b0;
`endif

    lsu_load_ext u_load_ext (
        .rdata     (mem_resp_rdata),
        .off       (alu_result_q[1:0]),
        .rmask     (rmask_q),
        .is_signed (signed_q),
        .data      (load_data)
    );

    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        alu_result_d = alu_result_q;
        rsb_d        = rsb_q;
        ren_d        = ren_q;
        wen_d        = wen_q;
        wmask_d      = wmask_q;
        rmask_d      = rmask_q;
        signed_d     = signed_q;
        mem_rdata_d  = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (lsu_receive_valid) begin
                    pass_d       = '{wd_op: wdOp_input, csrwd_op: csrwdOp_input,
                                     reg_write_en: reg_write_en_input,
                                     csreg_write_en: csreg_write_en_input,
                                     ecall: ecall_input, rd: rd_input, csr_rd: csr_rd_input,
                                     pc: pc_input, pc_next: pc_next_input,
                                     instruction: instruction_input};
                    alu_result_d = alu_result_input;
                    rsb_d        = rsb_input;
                    ren_d        = ren_input;
                    wen_d        = wen_input;
                    wmask_d      = wmask_input;
                    rmask_d      = rmask_input;
                    signed_d     = memory_read_signed_input;
                    mem_rdata_d  = '0;
                    state_d      = ((ren_input | wen_input) && !misalign_hit) ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (ren_q && !wen_q) begin
                        mem_rdata_d = load_data;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (lsu_receive_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pass_q       <= '0;
            alu_result_q <= '0;
            rsb_q        <= '0;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            wmask_q      <= '0;
            rmask_q      <= '0;
            signed_q     <= 1'b0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            pass_q       <= pass_d;
            alu_result_q <= alu_result_d;
            rsb_q        <= rsb_d;
            ren_q        <= ren_d;
            wen_q        <= wen_d;
            wmask_q      <= wmask_d;
            rmask_q      <= rmask_d;
            signed_q     <= signed_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign lsu_send_ready = (state_q == IDLE);
    assign lsu_send_valid = (state_q == DONE);
    assign mem_req_valid  = (state_q == REQ);
    assign mem_resp_ready = (state_q == WAIT);
    assign mem_req_addr   = {alu_result_q[31:2], 2'b00};
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = rsb_q << {alu_result_q[1:0], 3'b000};
    assign mem_req_wmask  = wmask_q << alu_result_q[1:0];

    assign alu_result     = alu_result_q;
    assign mem_rdata      = mem_rdata_q;
    assign wdOp           = pass_q.wd_op;
    assign csrwdOp        = pass_q.csrwd_op;
    assign reg_write_en   = pass_q.reg_write_en;
    assign csreg_write_en = pass_q.csreg_write_en;
    assign ecall          = pass_q.ecall;
    assign rd             = pass_q.rd;
    assign csr_rd         = pass_q.csr_rd;
    assign pc             = pass_q.pc;
    assign pc_next        = pass_q.pc_next;
    assign instruction    = pass_q.instruction;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu; define LSU_MISALIGN_CHECK_EN to cover the misalign build
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_receive_valid, lsu_send_ready;
    logic [31:0] alu_result_input, rsb_input, rmask_input;
    logic        ren_input, wen_input, memory_read_signed_input;
    logic [7:0]  wmask_input;
    logic [1:0]  wdOp_input, csr_rd_input;
    logic        csrwdOp_input, reg_write_en_input, csreg_write_en_input, ecall_input;
    logic [4:0]  rd_input;
    logic [31:0] pc_input, pc_next_input, instruction_input;
    logic        lsu_send_valid, lsu_receive_ready;
    logic [31:0] alu_result, mem_rdata, pc, pc_next, instruction;
    logic [1:0]  wdOp, csr_rd;
    logic        csrwdOp, reg_write_en, csreg_write_en, ecall;
    logic [4:0]  rd;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_resp_rdata;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        lsu_misalign;
`endif

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic [7:0]  wmask;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst),
        .lsu_receive_valid(lsu_receive_valid), .lsu_send_ready(lsu_send_ready),
        .alu_result_input(alu_result_input), .rsb_input(rsb_input),
        .ren_input(ren_input), .wen_input(wen_input), .wmask_input(wmask_input),
        .rmask_input(rmask_input), .memory_read_signed_input(memory_read_signed_input),
        .wdOp_input(wdOp_input), .csrwdOp_input(csrwdOp_input),
        .reg_write_en_input(reg_write_en_input), .csreg_write_en_input(csreg_write_en_input),
        .ecall_input(ecall_input), .rd_input(rd_input), .csr_rd_input(csr_rd_input),
        .pc_input(pc_input), .pc_next_input(pc_next_input), .instruction_input(instruction_input),
        .lsu_send_valid(lsu_send_valid), .lsu_receive_ready(lsu_receive_ready),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .wdOp(wdOp), .csrwdOp(csrwdOp),
        .reg_write_en(reg_write_en), .csreg_write_en(csreg_write_en), .ecall(ecall),
        .rd(rd), .csr_rd(csr_rd), .pc(pc), .pc_next(pc_next), .instruction(instruction),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
`ifdef LSU_MISALIGN_CHECK_EN
        .lsu_misalign(lsu_misalign),
`endif
        .mem_resp_rdata(mem_resp_rdata)
    );

    function automatic logic [31:0] model_load(logic [31:0] d, logic [1:0] off,
                                               logic [31:0] rm, logic sg);
        logic [7:0]  by [0:6];
        logic [31:0] r;
        by[0] = d[7:0];   by[1] = d[15:8]; by[2] = d[23:16]; by[3] = d[31:24];
        by[4] = 8'h00;    by[5] = 8'h00;   by[6] = 8'h00;
        if (rm == RMASK_BYTE)
            r = sg ? {{24{by[off][7]}}, by[off]} : {24'h0, by[off]};
        else if (rm == RMASK_HALF)
            r = sg ? {{16{by[off+1][7]}}, by[off+1], by[off]} : {16'h0, by[off+1], by[off]};
        else
            r = {by[off+3], by[off+2], by[off+1], by[off]};
        return r;
    endfunction

    function automatic logic [31:0] model_wdata(logic [31:0] v, logic [1:0] off);
        case (off)
            2'd0:    return v;
            2'd1:    return {v[23:0], 8'h00};
            2'd2:    return {v[15:0], 16'h0000};
            default: return {v[7:0], 24'h000000};
        endcase
    endfunction

    function automatic logic [7:0] model_wmask(logic [7:0] m, logic [1:0] off);
        case (off)
            2'd0:    return m;
            2'd1:    return {m[6:0], 1'b0};
            2'd2:    return {m[5:0], 2'b00};
            default: return {m[4:0], 3'b000};
        endcase
    endfunction

    task automatic idle_inputs();
        lsu_receive_valid = 0; lsu_receive_ready = 0;
        alu_result_input = 0; rsb_input = 0; rmask_input = 0; wmask_input = 0;
        ren_input = 0; wen_input = 0; memory_read_signed_input = 0;
        wdOp_input = 0; csr_rd_input = 0; csrwdOp_input = 0; reg_write_en_input = 0;
        csreg_write_en_input = 0; ecall_input = 0; rd_input = 0;
        pc_input = 0; pc_next_input = 0; instruction_input = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_txn(input logic [31:0] alu, input logic [31:0] rsb, input logic [31:0] rmask,
                           input logic ren, input logic wen, input logic sg, input logic [7:0] wmask,
                           input logic [4:0] rd_v, input logic [31:0] pc_v,
                           input int rdly, input int wdly, input logic [31:0] resp);
        exp_t e;
        req_t r, first;
        logic mis, is_mem, done;
        int   req_cycles, wait_cycles, done_idx, want_idx;
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        begin
            logic half_acc, word_acc;
            half_acc = wen ? (wmask == 8'h03) : (rmask == RMASK_HALF);
            word_acc = wen ? (wmask == 8'h0F) : (rmask == RMASK_WORD);
            mis = (ren | wen) && ((half_acc && alu[0]) || (word_acc && alu[1:0] != 2'b00));
        end
`endif
        is_mem = (ren | wen) && !mis;
        total++; if (lsu_send_ready !== 1'b1) begin bad++; $display("FAIL send_ready_idle got %b want 1", lsu_send_ready); end

        alu_result_input = alu; rsb_input = rsb; rmask_input = rmask; ren_input = ren;
        wen_input = wen; memory_read_signed_input = sg; wmask_input = wmask; rd_input = rd_v;
        pc_input = pc_v; pc_next_input = pc_v + 4; instruction_input = {pc_v[15:0], alu[15:0]};
        wdOp_input = rd_v[1:0]; csr_rd_input = rd_v[3:2]; ecall_input = rd_v[4];
        lsu_receive_valid = 1;

        e.alu = alu; e.pc = pc_v; e.insn = {pc_v[15:0], alu[15:0]}; e.rd = rd_v; e.mis = mis;
        e.rdata = (is_mem && ren && !wen) ? model_load(resp, alu[1:0], rmask, sg) : 32'h0;
        exp_q.push_back(e);
        if (is_mem) begin
            r.addr = {alu[31:2], 2'b00}; r.wen = wen;
            r.wdata = model_wdata(rsb, alu[1:0]); r.wmask = model_wmask(wmask, alu[1:0]);
            req_q.push_back(r);
        end

        @(negedge clk);
        lsu_receive_valid = 0;
        total++; if (lsu_send_ready !== 1'b0) begin bad++; $display("FAIL send_ready_busy got %b want 0", lsu_send_ready); end

        done = 0; req_cycles = 0; wait_cycles = 0; done_idx = -1;
        first = '{default: '0};
        for (int c = 0; c < 64 && !done; c++) begin
            if (mem_req_valid) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    total++;
                    if (req_q.size() == 0) begin
                        bad++; $display("FAIL unexpected_req got addr %h want no request", mem_req_addr);
                    end else begin
                        first = req_q.pop_front();
                        if (mem_req_addr !== first.addr) begin bad++; $display("FAIL req_addr got %h want %h", mem_req_addr, first.addr); end
                        total++; if (mem_req_wen !== first.wen) begin bad++; $display("FAIL req_wen got %b want %b", mem_req_wen, first.wen); end
                        if (first.wen) begin
                            total++; if (mem_req_wdata !== first.wdata) begin bad++; $display("FAIL req_wdata got %h want %h", mem_req_wdata, first.wdata); end
                            total++; if (mem_req_wmask !== first.wmask) begin bad++; $display("FAIL req_wmask got %h want %h", mem_req_wmask, first.wmask); end
                        end
                    end
                end else begin
                    total++; if (mem_req_addr !== first.addr) begin bad++; $display("FAIL req_addr_stable got %h want %h", mem_req_addr, first.addr); end
                end
                mem_req_ready = (req_cycles > rdly);
            end else begin
                mem_req_ready = 0;
            end
            if (mem_resp_ready) begin
                wait_cycles++;
                mem_resp_valid = (wait_cycles > wdly);
                mem_resp_rdata = resp;
            end else begin
                mem_resp_valid = 0;
            end
            if (lsu_send_valid) begin
                done = 1; done_idx = c;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL unexpected_result got alu %h want no result", alu_result);
                end else begin
                    e = exp_q.pop_front();
                    if (alu_result !== e.alu) begin bad++; $display("FAIL alu_result got %h want %h", alu_result, e.alu); end
                    total++; if (mem_rdata !== e.rdata) begin bad++; $display("FAIL mem_rdata got %h want %h", mem_rdata, e.rdata); end
                    total++; if (rd !== e.rd || pc !== e.pc || pc_next !== e.pc + 4) begin bad++; $display("FAIL pass_rd_pc got %h/%h want %h/%h", rd, pc, e.rd, e.pc); end
                    total++; if (instruction !== e.insn || wdOp !== e.rd[1:0] || ecall !== e.rd[4]) begin bad++; $display("FAIL pass_insn got %h want %h", instruction, e.insn); end
`ifdef LSU_MISALIGN_CHECK_EN
                    total++; if (lsu_misalign !== e.mis) begin bad++; $display("FAIL misalign got %b want %b", lsu_misalign, e.mis); end
`endif
                end
                lsu_receive_ready = 1;
            end
            @(negedge clk);
        end
        want_idx = is_mem ? 2 + rdly + wdly : 0;
        total++; if (done_idx != want_idx) begin bad++; $display("FAIL latency got %0d want %0d", done_idx, want_idx); end
        total++; if (req_cycles != (is_mem ? rdly + 1 : 0)) begin bad++; $display("FAIL req_cycles got %0d want %0d", req_cycles, is_mem ? rdly + 1 : 0); end
        total++; if (lsu_send_valid !== 1'b0 || lsu_send_ready !== 1'b1) begin bad++; $display("FAIL single_done got valid %b ready %b want 0 1", lsu_send_valid, lsu_send_ready); end
        lsu_receive_ready = 0; mem_req_ready = 0; mem_resp_valid = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        #3;
        total++; if (lsu_send_valid !== 0 || mem_req_valid !== 0 || mem_resp_ready !== 0 || mem_req_wen !== 0) begin bad++; $display("FAIL reset_ctrl got %b%b%b%b want 0000", lsu_send_valid, mem_req_valid, mem_resp_ready, mem_req_wen); end
        total++; if (alu_result !== 0 || mem_rdata !== 0 || pc !== 0 || rd !== 0 || instruction !== 0) begin bad++; $display("FAIL reset_data got alu %h rdata %h want 0", alu_result, mem_rdata); end
        total++; if (lsu_send_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", lsu_send_ready); end
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_non_mem();
        run_txn(32'h0000_1234, 32'h0, RMASK_WORD, 0, 0, 0, 8'h00, 5'd7, 32'h8000_0100, 0, 0, 32'h0);
        run_txn(32'hFFFF_FFFF, 32'h5555_AAAA, RMASK_BYTE, 0, 0, 1, 8'h0F, 5'd31, 32'h8000_0104, 0, 0, 32'h0);
    endtask

    task automatic test_load();
        run_txn(32'h8000_0003, 32'h0, RMASK_BYTE, 1, 0, 1, 8'h00, 5'd1, 32'h8000_0200, 0, 0, 32'h80FF_FFFF);
        run_txn(32'h8000_0001, 32'h0, RMASK_BYTE, 1, 0, 0, 8'h00, 5'd2, 32'h8000_0204, 0, 0, 32'h0000_A500);
        run_txn(32'h8000_0002, 32'h0, RMASK_HALF, 1, 0, 0, 8'h00, 5'd3, 32'h8000_0208, 1, 0, 32'h8001_1234);
        run_txn(32'h8000_0002, 32'h0, RMASK_HALF, 1, 0, 1, 8'h00, 5'd4, 32'h8000_020C, 0, 1, 32'h8001_1234);
        run_txn(32'h8000_0010, 32'h0, RMASK_WORD, 1, 0, 1, 8'h00, 5'd5, 32'h8000_0210, 0, 0, 32'hCAFE_F00D);
    endtask

    task automatic test_store();
        run_txn(32'h8000_0002, 32'h0000_ABCD, RMASK_WORD, 0, 1, 0, 8'h03, 5'd6, 32'h8000_0300, 0, 0, 32'h0);
        run_txn(32'h8000_0001, 32'h0000_005A, RMASK_WORD, 0, 1, 0, 8'h01, 5'd8, 32'h8000_0304, 0, 0, 32'h0);
        run_txn(32'h8000_0020, 32'h1234_5678, RMASK_WORD, 0, 1, 0, 8'h0F, 5'd9, 32'h8000_0308, 2, 2, 32'h0);
        // ren and wen together behave as a store and report no load data.
        run_txn(32'h8000_0002, 32'h0000_BEEF, RMASK_HALF, 1, 1, 1, 8'h03, 5'd10, 32'h8000_030C, 0, 0, 32'hFFFF_FFFF);
    endtask

    task automatic test_backpressure();
        run_txn(32'h8000_0040, 32'h0, RMASK_WORD, 1, 0, 0, 8'h00, 5'd11, 32'h8000_0400, 5, 3, 32'h0BAD_CAFE);
    endtask

    task automatic test_misalign();
        run_txn(32'h8000_0001, 32'h0, RMASK_WORD, 1, 0, 0, 8'h00, 5'd12, 32'h8000_0500, 0, 0, 32'h1122_3344);
        run_txn(32'h8000_0003, 32'h0000_ABCD, RMASK_WORD, 0, 1, 0, 8'h03, 5'd13, 32'h8000_0504, 0, 0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d;
        for (int i = 0; i < 9; i++) begin
            d = $urandom;
            case (i % 4)
                0: begin a = 32'h8000_1000 + 32'($urandom_range(0, 3)); run_txn(a, 0, RMASK_BYTE, 1, 0, i[0], 8'h00, 5'(i), a, $urandom_range(0, 2), $urandom_range(0, 2), d); end
                1: begin a = 32'h8000_1000 + 32'(2 * $urandom_range(0, 1)); run_txn(a, 0, RMASK_HALF, 1, 0, i[1], 8'h00, 5'(i), a, $urandom_range(0, 2), $urandom_range(0, 2), d); end
                2: begin a = 32'h8000_1000 + 32'(2 * $urandom_range(0, 1)); run_txn(a, d, RMASK_WORD, 0, 1, 0, 8'h03, 5'(i), a, $urandom_range(0, 2), $urandom_range(0, 2), 0); end
                default: begin a = d; run_txn(a, 0, RMASK_WORD, 0, 0, 0, 8'h00, 5'(i), a, 0, 0, 0); end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        alu_result_input = 32'h8000_0010; ren_input = 1; wen_input = 0; rmask_input = RMASK_WORD;
        lsu_receive_valid = 1;
        @(negedge clk);
        lsu_receive_valid = 0;
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL mid_req_valid got %b want 1", mem_req_valid); end
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        total++; if (mem_resp_ready !== 1'b1) begin bad++; $display("FAIL mid_wait got %b want 1", mem_resp_ready); end
        #2 rst = 0;
        #1;
        total++; if (mem_req_valid !== 0 || mem_resp_ready !== 0 || lsu_send_valid !== 0) begin bad++; $display("FAIL async_reset_wait got %b%b%b want 000", mem_req_valid, mem_resp_ready, lsu_send_valid); end
        @(negedge clk);
        rst = 1;
        // Store sitting in REQ must drop its request the instant reset asserts.
        alu_result_input = 32'h8000_0020; ren_input = 0; wen_input = 1; wmask_input = 8'h0F;
        lsu_receive_valid = 1;
        @(negedge clk);
        lsu_receive_valid = 0;
        #2 rst = 0;
        #1;
        total++; if (mem_req_valid !== 1'b0 || mem_req_wen !== 1'b0) begin bad++; $display("FAIL async_reset_req got %b%b want 00", mem_req_valid, mem_req_wen); end
        @(negedge clk);
        rst = 1;
        mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (lsu_send_valid !== 0 || mem_resp_ready !== 0 || mem_rdata !== 0 || lsu_send_ready !== 1) begin bad++; $display("FAIL stray_resp got valid %b rdata %h want 0 0", lsu_send_valid, mem_rdata); end
        end
        mem_resp_valid = 0;
        idle_inputs();
        exp_q.delete();
        req_q.delete();
        @(negedge clk);
        run_txn(32'h0000_1234, 32'h0, RMASK_WORD, 0, 0, 0, 8'h00, 5'd20, 32'h8000_0600, 0, 0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_non_mem();
        test_load();
        test_store();
        test_backpressure();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-003 lsu_receive_valid  in  1  upstream (exu) holds a valid instruction bundle.
REQ-004 lsu_send_ready  out  1  lsu can accept a bundle this cycle; combinational, equals (state==IDLE).
REQ-005 Bundle inputs (in): alu_result_input 32, rsb_input 32, ren_input 1, wen_input 1, wmask_input 8, rmask_input 32, memory_read_signed_input 1.
REQ-006 Pass-through inputs (in): wdOp_input 2, csrwdOp_input 1, reg_write_en_input 1, csreg_write_en_input 1, ecall_input 1, rd_input 5, csr_rd_input 2, pc_input 32, pc_next_input 32, instruction_input 32.
REQ-007 lsu_send_valid  out  1  registered result valid toward wbu.
REQ-008 lsu_receive_ready  in  1  wbu accepts result this cycle.
REQ-009 Registered outputs: alu_result 32, mem_rdata 32 (aligned, extended load data), plus every REQ-006 field without the _input suffix, same widths.
REQ-010 mem_req_valid out 1; mem_req_ready in 1; mem_req_addr out 32; mem_req_wen out 1; mem_req_wdata out 32; mem_req_wmask out 8.
REQ-011 mem_resp_valid in 1; mem_resp_ready out 1; mem_resp_rdata in 32.

Function
REQ-012 FSM states IDLE, REQ, WAIT, DONE; encoding from shared package.
REQ-013 IDLE: on lsu_receive_valid, capture all bundle and pass-through inputs; go REQ if ren_input|wen_input, else DONE.
REQ-014 REQ: mem_req_valid=1 with stable addr/wen/wdata/wmask; on mem_req_ready go WAIT; hold otherwise.
REQ-015 WAIT: mem_resp_ready=1; on mem_resp_valid capture load result into mem_rdata (loads only) and go DONE.
REQ-016 DONE: lsu_send_valid=1, outputs stable; on lsu_receive_ready go IDLE; no new bundle accepted in the same cycle.
REQ-017 mem_req_addr = alu_result word-aligned ({addr[31:2],2'b00}); off = alu_result[1:0].
REQ-018 Store: mem_req_wdata = rsb << (8*off); mem_req_wmask = wmask << off, truncated to 8 bits; mem_req_wen=1.
REQ-019 Load: raw = mem_resp_rdata >> (8*off); mem_rdata = raw & rmask; if memory_read_signed, sign-extend from bit 7 (rmask=0x000000FF) or bit 15 (rmask=0x0000FFFF); rmask=0xFFFFFFFF unchanged.
REQ-020 ren and wen both set: perform the store only; mem_rdata=0.
REQ-021 Non-memory bundle: mem_rdata=0, memory interface untouched.
REQ-022 Latency: non-memory accepted at edge N -> lsu_send_valid high after edge N+1; memory op with zero-wait memory -> after edge N+3.
REQ-023 mem_req_valid, once raised, stays high until mem_req_ready; mem_resp_valid outside WAIT is ignored.

Reset
REQ-024 On rst low: state=IDLE; lsu_send_valid, mem_req_valid, mem_resp_ready, mem_req_wen=0; all registered data outputs = 0.
REQ-025 Reset mid-transaction abandons it; mem_req_valid deasserts asynchronously; no response is consumed after release.

Configuration
REQ-026 LSU_MISALIGN_CHECK_EN defined: half access with off[0]=1 or word access with off!=0 skips memory (IDLE->DONE), sets out lsu_misalign=1 with the result; undefined: port absent, access proceeds per REQ-017..019 with bytes beyond the word dropped.

Structure
REQ-027 Shared package holds lsu state enum and rmask constants BYTE=0xFF, HALF=0xFFFF, WORD=0xFFFFFFFF.
REQ-028 One combinational sub-module lsu_load_ext performs REQ-019 alignment, masking, extension.

Verification
REQ-029 Non-memory, alu_result=0x1234, lsu_receive_ready=1 -> send_valid after one cycle, alu_result=0x1234, mem_rdata=0, no mem_req_valid.
REQ-030 Load byte signed, addr=0x80000003, resp_rdata=0x80FFFFFF -> mem_req_addr=0x80000000, mem_rdata=0xFFFFFF80.
REQ-031 Store half, addr=0x80000002, rsb=0xABCD, wmask=0x03 -> wdata=0xABCD0000, wmask=0x0C, wen=1.
REQ-032 mem_req_ready low 5 cycles then high, resp 3 cycles later -> req_valid held 6 cycles, addr stable, single DONE.
REQ-033 rst low during WAIT -> mem_req_valid, mem_resp_ready, send_valid 0 immediately; later resp_valid ignored.
REQ-034 LSU_MISALIGN_CHECK_EN, word load addr=0x80000001 -> no mem_req_valid, lsu_misalign=1, send_valid after one cycle.
